// File: rtl/knn_topk_sorter_pkg.sv
// knn_topk_sorter_pkg
//   Shared definitions for the top-K insertion sorter:
//   - default DATA_W / IDX_W / K values
//   - FSM state encoding (00 IDLE, 01 RUN, 10 HOLD)
package knn_topk_sorter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 8;
  localparam int DEF_K      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/knn_topk_sorter_cell.sv
// knn_sort_cell
//   One slot of the top-K insertion sorter: distance, sample index and
//   valid registers, plus this slot's compare and its load/shift mux.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   clr_i                          synchronous slot clear
//   ins_i                          a sample is accepted this cycle
//   in_data_i, in_idx_i            incoming distance and its index
//   c_prev_i                       compare result of the previous slot (0 for slot 0)
//   prev_data_i/idx_i/valid_i      contents of the previous slot
//   c_o                            this slot's compare result
//   data_o, idx_o, valid_o         contents of this slot
module knn_sort_cell #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              ins_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [IDX_W-1:0]  in_idx_i,
  input  logic              c_prev_i,
  input  logic [DATA_W-1:0] prev_data_i,
  input  logic [IDX_W-1:0]  prev_idx_i,
  input  logic              prev_valid_i,
  output logic              c_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;

  // An empty slot always accepts; strict less-than keeps the older of two
  // equal distances ahead, so the ordering is stable.
  assign c_o = !valid_q || (in_data_i < data_q);

  // Next-state mux: clear, insert here, shift down from the previous slot, or hold.
  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (clr_i) begin
      data_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
    end else if (ins_i) begin
      if (c_o && !c_prev_i) begin
        // First slot whose compare fires: the new sample lands here.
        data_d  = in_data_i;
        idx_d   = in_idx_i;
        valid_d = 1'b1;
      end else if (c_prev_i) begin
        // Insertion happened above: everything below moves down by one.
        data_d  = prev_data_i;
        idx_d   = prev_idx_i;
        valid_d = prev_valid_i;
      end else begin
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
      end
    end else begin
      data_d  = data_q;
      idx_d   = idx_q;
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/knn_topk_sorter.sv
// knn_topk_sorter
//   Streaming top-K insertion sorter. Keeps the K smallest distances of a
//   stream together with the arrival index of each sample.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin a new stream (from IDLE or HOLD)
//   clear               return to IDLE and empty the table
//   done                end of stream, freeze the table
//   in_valid/in_ready   sample handshake, in_data = distance
//   rd_sel              slot to read (0 = smallest)
//   rd_data/rd_idx      contents of the selected slot
//   rd_valid            selected slot is occupied
//   count               occupied slots, saturates at K
//   idx_ovf             sticky: index counter wrapped
//   state_o             FSM state (00 IDLE, 01 RUN, 10 HOLD)
module knn_topk_sorter
  import knn_topk_sorter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int K      = DEF_K,
  localparam int SEL_W = (K > 1) ? $clog2(K) : 1,
  localparam int CNT_W = $clog2(K + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  count,
  output logic              idx_ovf,
  output logic [1:0]        state_o
);

  state_e            state_q;
  logic              in_ready_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  count_q;

  logic              acc_s;
  logic              clr_s;
  logic [K-1:0]      c_s;
  logic [DATA_W-1:0] data_s  [K];
  logic [IDX_W-1:0]  idx_s   [K];
  logic [K-1:0]      valid_s;

  // clear beats everything, so a sample presented alongside it is dropped.
  assign acc_s = in_valid && in_ready_q && !clear;
  // Slots empty on clear, and on a start that actually opens a new stream
  // (start inside RUN is ignored).
  assign clr_s = clear || (start && (state_q != ST_RUN));

  genvar g;
  generate
    for (g = 0; g < K; g++) begin : gen_cell
      logic              c_prev_s;
      logic [DATA_W-1:0] prev_data_s;
      logic [IDX_W-1:0]  prev_idx_s;
      logic              prev_valid_s;

      if (g == 0) begin : gen_head
        assign c_prev_s     = 1'b0;
        assign prev_data_s  = '0;
        assign prev_idx_s   = '0;
        assign prev_valid_s = 1'b0;
      end else begin : gen_body
        assign c_prev_s     = c_s[g-1];
        assign prev_data_s  = data_s[g-1];
        assign prev_idx_s   = idx_s[g-1];
        assign prev_valid_s = valid_s[g-1];
      end

      knn_sort_cell #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
      ) u_cell (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr_s),
        .ins_i        (acc_s),
        .in_data_i    (in_data),
        .in_idx_i     (idx_q),
        .c_prev_i     (c_prev_s),
        .prev_data_i  (prev_data_s),
        .prev_idx_i   (prev_idx_s),
        .prev_valid_i (prev_valid_s),
        .c_o          (c_s[g]),
        .data_o       (data_s[g]),
        .idx_o        (idx_s[g]),
        .valid_o      (valid_s[g])
      );
    end
  endgenerate

  // Control FSM with its counters; in_ready is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else if (clear) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (start) begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b1;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
          end
        end
        ST_RUN: begin
          if (acc_s) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == {IDX_W{1'b1}}) begin
              ovf_q <= 1'b1;
            end
            if (count_q < CNT_W'(K)) begin
              count_q <= count_q + CNT_W'(1);
            end
          end
          // A sample accepted together with done still lands before the freeze.
          if (done) begin
            state_q    <= ST_HOLD;
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Readout mux; selects outside 0..K-1 read as an empty slot.
  always_comb begin
    rd_data  = '0;
    rd_idx   = '0;
    rd_valid = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data  = data_s[i];
        rd_idx   = idx_s[i];
        rd_valid = valid_s[i];
      end else begin
        rd_valid = rd_valid;
      end
    end
  end

  assign in_ready = in_ready_q;
  assign count    = count_q;
  assign idx_ovf  = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Bench for knn_topk_sorter. Two instances share the stimulus:
//   A: defaults (K=4, IDX_W=8)
//   B: K=3, IDX_W=2 (index wrap, overflow flag, rd_sel beyond K)
// A reference model computes the expected table for every cycle, pushes it
// into a scoreboard queue, and the entry is popped and compared after the edge.
module tb_knn_topk_sorter;

  logic        clk = 1'b0;
  logic        rst, start, clear, done, in_valid;
  logic [31:0] in_data;
  logic [1:0]  rd_sel;

  logic        a_ready, a_rd_valid, a_ovf;
  logic [31:0] a_rd_data;
  logic [7:0]  a_rd_idx;
  logic [2:0]  a_count;
  logic [1:0]  a_state;

  logic        b_ready, b_rd_valid, b_ovf;
  logic [31:0] b_rd_data;
  logic [1:0]  b_rd_idx;
  logic [1:0]  b_count;
  logic [1:0]  b_state;

  knn_topk_sorter u_dut_a (
    .clk (clk), .rst (rst), .start (start), .clear (clear), .done (done),
    .in_valid (in_valid), .in_ready (a_ready), .in_data (in_data),
    .rd_sel (rd_sel), .rd_data (a_rd_data), .rd_idx (a_rd_idx),
    .rd_valid (a_rd_valid), .count (a_count), .idx_ovf (a_ovf),
    .state_o (a_state)
  );

  knn_topk_sorter #(.DATA_W (32), .IDX_W (2), .K (3)) u_dut_b (
    .clk (clk), .rst (rst), .start (start), .clear (clear), .done (done),
    .in_valid (in_valid), .in_ready (b_ready), .in_data (in_data),
    .rd_sel (rd_sel), .rd_data (b_rd_data), .rd_idx (b_rd_idx),
    .rd_valid (b_rd_valid), .count (b_count), .idx_ovf (b_ovf),
    .state_o (b_state)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0][31:0] s;
    logic [3:0]       v;
    logic [31:0]      cnt;
  } tbl_t;

  typedef struct packed {
    tbl_t        a;
    tbl_t        b;
    logic [31:0] seq;
    logic [1:0]  st;
  } snap_t;

  tbl_t       ma, mb;
  int         seq;
  logic [1:0] mst;
  snap_t      sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sorted insert by position search: first slot that is empty or strictly larger.
  function automatic tbl_t ins(input tbl_t t, input logic [31:0] x,
                               input logic [31:0] sq, input int k);
    tbl_t r;
    int   p;
    r = t;
    p = k;
    for (int i = k - 1; i >= 0; i--) begin
      if (!t.v[i] || x < t.d[i]) p = i;
    end
    if (p < k) begin
      for (int i = k - 1; i > p; i--) begin
        r.d[i] = t.d[i-1];
        r.s[i] = t.s[i-1];
        r.v[i] = t.v[i-1];
      end
      r.d[p] = x;
      r.s[p] = sq;
      r.v[p] = 1'b1;
    end
    if (t.cnt < 32'(k)) r.cnt = t.cnt + 32'd1;
    return r;
  endfunction

  task automatic step(input logic r, input logic s, input logic c, input logic dn,
                      input logic v, input logic [31:0] x);
    snap_t e;
    @(negedge clk);
    rst = r; start = s; clear = c; done = dn; in_valid = v; in_data = x;
    if (r || c) begin
      ma = '0; mb = '0; seq = 0; mst = 2'b00;
    end else begin
      case (mst)
        2'b00, 2'b10: if (s) begin ma = '0; mb = '0; seq = 0; mst = 2'b01; end
        2'b01: begin
          if (v) begin
            ma = ins(ma, x, 32'(seq), 4);
            mb = ins(mb, x, 32'(seq), 3);
            seq++;
          end
          if (dn) mst = 2'b10;
        end
        default: mst = 2'b00;
      endcase
    end
    e.a = ma; e.b = mb; e.seq = 32'(seq); e.st = mst;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("a_state", 64'(a_state), 64'(e.st));
    chk("a_ready", 64'(a_ready), 64'(e.st == 2'b01));
    chk("a_count", 64'(a_count), 64'(e.a.cnt));
    chk("a_ovf",   64'(a_ovf),   64'(e.seq >= 32'd256));
    chk("b_state", 64'(b_state), 64'(e.st));
    chk("b_ready", 64'(b_ready), 64'(e.st == 2'b01));
    chk("b_count", 64'(b_count), 64'(e.b.cnt));
    chk("b_ovf",   64'(b_ovf),   64'(e.seq >= 32'd4));
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      chk($sformatf("a_data%0d", i),  64'(a_rd_data),  64'(e.a.d[i]));
      chk($sformatf("a_idx%0d", i),   64'(a_rd_idx),   64'(e.a.s[i][7:0]));
      chk($sformatf("a_valid%0d", i), 64'(a_rd_valid), 64'(e.a.v[i]));
      chk($sformatf("b_data%0d", i),  64'(b_rd_data),  64'(e.b.d[i]));
      chk($sformatf("b_idx%0d", i),   64'(b_rd_idx),   64'(e.b.s[i][1:0]));
      chk($sformatf("b_valid%0d", i), 64'(b_rd_valid), 64'(e.b.v[i]));
    end
  endtask

  task automatic feed(input logic [31:0] x);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, x);
  endtask

  task automatic go();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; done = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; rd_sel = 2'd0;
    ma = '0; mb = '0; seq = 0; mst = 2'b00;

    // Reset state, then idle with a stray sample that must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);

    // Basic ordering, then eviction of larger samples once full.
    go();
    feed(32'd50); feed(32'd20); feed(32'd70); feed(32'd10);
    feed(32'd30); feed(32'd80);
    // start inside RUN is ignored; the sample still goes in.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

    // Ties keep arrival order (restart from HOLD).
    go();
    feed(32'd20); feed(32'd20); feed(32'd5);

    // Partial stream with all-ones sample and done alongside the last sample.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    go();
    feed(32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd7);
    feed(32'd1);

    // Mid-stream clear together with a sample, then a fresh stream.
    go();
    feed(32'd3); feed(32'd2); feed(32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd9);
    go();
    feed(32'd4);

    // Index wrap on the narrow instance, then start clears the flag.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    go();
    feed(32'd9); feed(32'd8); feed(32'd7); feed(32'd6); feed(32'd5);
    feed(32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    go();

    // Random stream with gaps, small values for frequent ties.
    for (int n = 0; n < 80; n++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 3) != 0),
           32'($urandom_range(0, 40)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
